// File: rtl/rggen_register_bus_arbiter_pkg.sv
// Local types for the register bus arbiter: FSM state and pointer sizing.
package rggen_register_bus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // A single requester still needs a one-bit pointer to keep port widths legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rggen_rtl_pkg.sv
// Shared rggen register-bus encodings for access kind and response status.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

endpackage

// File: rtl/rggen_round_robin_arbiter.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rggen_round_robin_arbiter
    import rggen_register_bus_arbiter_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = ptr_width(N)
) (
    input  logic [N-1:0]  i_request,
    input  logic [PW-1:0] i_pointer,
    output logic [N-1:0]  o_grant
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        o_grant = '0;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, i_pointer} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && i_request[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rggen_register_bus_arbiter.sv
// Shares one downstream rggen register bus between several masters with
// non-preemptive round-robin arbitration and per-owner response routing.
module rggen_register_bus_arbiter
    import rggen_rtl_pkg::*;
    import rggen_register_bus_arbiter_pkg::*;
#(
    parameter int N_REQUESTERS  = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [N_REQUESTERS-1:0]           i_req_valid,
    input  logic [N_REQUESTERS*2-1:0]         i_req_access,
    input  logic [N_REQUESTERS*ADDRESS_WIDTH-1:0] i_req_address,
    input  logic [N_REQUESTERS*BUS_WIDTH-1:0] i_req_write_data,
    input  logic [N_REQUESTERS*BUS_WIDTH/8-1:0] i_req_strobe,
    output logic [N_REQUESTERS-1:0]           o_req_ready,
    output logic [N_REQUESTERS*2-1:0]         o_req_status,
    output logic [N_REQUESTERS*BUS_WIDTH-1:0] o_req_read_data,
    output logic                              o_valid,
    output logic [1:0]                        o_access,
    output logic [ADDRESS_WIDTH-1:0]          o_address,
    output logic [BUS_WIDTH-1:0]              o_write_data,
    output logic [BUS_WIDTH/8-1:0]            o_strobe,
    input  logic                              i_ready,
    input  logic [1:0]                        i_status,
    input  logic [BUS_WIDTH-1:0]              i_read_data,
    output logic [N_REQUESTERS-1:0]           o_grant
);

    localparam int SW = BUS_WIDTH / 8;
    localparam int PW = ptr_width(N_REQUESTERS);

    arb_state_e                state_q;
    arb_state_e                state_d;
    logic [PW-1:0]             pointer_q;
    logic [PW-1:0]             owner_q;
    logic [N_REQUESTERS-1:0]   grant_q;
    logic [N_REQUESTERS-1:0]   win;
    logic [PW-1:0]             win_index;
    logic [1:0]                win_access;
    logic [ADDRESS_WIDTH-1:0]  win_address;
    logic [BUS_WIDTH-1:0]      win_write_data;
    logic [SW-1:0]             win_strobe;
    logic                      start_access;
    logic                      end_access;

    rggen_round_robin_arbiter #(
        .N (N_REQUESTERS)
    ) u_arbiter (
        .i_request (i_req_valid),
        .i_pointer (pointer_q),
        .o_grant   (win)
    );

    assign start_access = (state_q == ARB_IDLE) && (|i_req_valid);
    assign end_access   = (state_q == ARB_BUSY) && i_ready;
    assign o_valid      = (state_q == ARB_BUSY);
    assign o_grant      = grant_q;

    // Select the winning requester's command lanes; the grant is one-hot so OR-ing is safe.
    always_comb begin
        win_index      = '0;
        win_access     = '0;
        win_address    = '0;
        win_write_data = '0;
        win_strobe     = '0;
        for (int i = 0; i < N_REQUESTERS; i++) begin
            if (win[i]) begin
                win_index      = PW'(i);
                win_access     = win_access | i_req_access[i*2 +: 2];
                win_address    = win_address | i_req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                win_write_data = win_write_data | i_req_write_data[i*BUS_WIDTH +: BUS_WIDTH];
                win_strobe     = win_strobe | i_req_strobe[i*SW +: SW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (start_access) state_d = ARB_BUSY;
            ARB_BUSY: if (i_ready)      state_d = ARB_IDLE;
            default:                    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The command is captured once at grant so later upstream changes cannot disturb the access.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            grant_q      <= '0;
            owner_q      <= '0;
            pointer_q    <= '0;
            o_access     <= '0;
            o_address    <= '0;
            o_write_data <= '0;
            o_strobe     <= '0;
        end else if (start_access) begin
            grant_q      <= win;
            owner_q      <= win_index;
            o_access     <= win_access;
            o_address    <= win_address;
            o_write_data <= win_write_data;
            o_strobe     <= win_strobe;
        end else if (end_access) begin
            grant_q   <= '0;
            pointer_q <= (owner_q == PW'(N_REQUESTERS - 1)) ? '0 : owner_q + PW'(1);
        end
    end

    always_comb begin
        o_req_ready     = '0;
        o_req_status    = '0;
        o_req_read_data = '0;
        if (end_access) begin
            for (int i = 0; i < N_REQUESTERS; i++) begin
                if (grant_q[i]) begin
                    o_req_ready[i]                             = 1'b1;
                    o_req_status[i*2 +: 2]                     = i_status;
                    o_req_read_data[i*BUS_WIDTH +: BUS_WIDTH]  = i_read_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_rggen_register_bus_arbiter.sv
// Scoreboard-driven bench for the two-requester register bus arbiter.
module tb_rggen_register_bus_arbiter;
    import rggen_rtl_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  i_req_valid;
    logic [3:0]  i_req_access;
    logic [15:0] i_req_address;
    logic [63:0] i_req_write_data;
    logic [7:0]  i_req_strobe;
    logic [1:0]  o_req_ready;
    logic [3:0]  o_req_status;
    logic [63:0] o_req_read_data;
    logic        o_valid;
    logic [1:0]  o_access;
    logic [7:0]  o_address;
    logic [31:0] o_write_data;
    logic [3:0]  o_strobe;
    logic        i_ready;
    logic [1:0]  i_status;
    logic [31:0] i_read_data;
    logic [1:0]  o_grant;

    typedef struct {
        int          owner;
        logic [1:0]  status;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_ptr = 0;

    rggen_register_bus_arbiter #(
        .N_REQUESTERS  (2),
        .ADDRESS_WIDTH (8),
        .BUS_WIDTH     (32)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_req_valid      (i_req_valid),
        .i_req_access     (i_req_access),
        .i_req_address    (i_req_address),
        .i_req_write_data (i_req_write_data),
        .i_req_strobe     (i_req_strobe),
        .o_req_ready      (o_req_ready),
        .o_req_status     (o_req_status),
        .o_req_read_data  (o_req_read_data),
        .o_valid          (o_valid),
        .o_access         (o_access),
        .o_address        (o_address),
        .o_write_data     (o_write_data),
        .o_strobe         (o_strobe),
        .i_ready          (i_ready),
        .i_status         (i_status),
        .i_read_data      (i_read_data),
        .o_grant          (o_grant)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic v, input logic [1:0] acc,
                           input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] strb);
        i_req_valid[idx]             = v;
        i_req_access[idx*2 +: 2]     = acc;
        i_req_address[idx*8 +: 8]    = addr;
        i_req_write_data[idx*32 +: 32] = wd;
        i_req_strobe[idx*4 +: 4]     = strb;
    endtask

    task automatic apply_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic wait_busy(input int max_cycles, input string name);
        for (int k = 0; k < max_cycles && o_valid !== 1'b1; k++) tick();
        checks++;
        if (o_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_timeout: o_valid=%b required 1", name, o_valid);
        end
    endtask

    // Downstream completes the access; the expected routed response goes on the scoreboard first.
    task automatic respond(input int owner, input logic [1:0] st, input logic [31:0] rd);
        exp_t        e;
        exp_t        got;
        logic [1:0]  exp_ready;
        logic [3:0]  exp_status;
        logic [63:0] exp_data;
        e.owner = owner;
        e.status = st;
        e.data = rd;
        exp_q.push_back(e);
        i_ready = 1'b1;
        i_status = st;
        i_read_data = rd;
        #1;
        got = exp_q.pop_front();
        exp_ready = '0;
        exp_status = '0;
        exp_data = '0;
        exp_ready[got.owner] = 1'b1;
        exp_status[got.owner*2 +: 2] = got.status;
        exp_data[got.owner*32 +: 32] = got.data;
        checks++;
        if (o_req_ready !== exp_ready) begin
            errors++;
            $display("[TB] FAIL resp_ready: got %b required %b", o_req_ready, exp_ready);
        end
        checks++;
        if (o_req_status !== exp_status) begin
            errors++;
            $display("[TB] FAIL resp_status: got %h required %h", o_req_status, exp_status);
        end
        checks++;
        if (o_req_read_data !== exp_data) begin
            errors++;
            $display("[TB] FAIL resp_data: got %h required %h", o_req_read_data, exp_data);
        end
        tick();
        i_ready = 1'b0;
        i_status = '0;
        i_read_data = '0;
        exp_ptr = (owner + 1) % 2;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_grant !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_valid_grant: got valid=%b grant=%b required 0/00", o_valid, o_grant);
        end
        checks++;
        if ({o_access, o_address, o_write_data, o_strobe} !== 46'd0) begin
            errors++;
            $display("[TB] FAIL reset_command: got %h %h %h %h required zeros", o_access, o_address, o_write_data, o_strobe);
        end
        checks++;
        if (o_req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ready: got %b required 00", o_req_ready);
        end
        tick();
        i_rst_n = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, RGGEN_WRITE, 8'h10, 32'hDEAD_BEEF, 4'hF);
        #1;
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL write_latency: o_valid=%b required 0 before edge", o_valid);
        end
        tick();
        checks++;
        if (o_valid !== 1'b1 || o_grant !== 2'b01) begin
            errors++;
            $display("[TB] FAIL write_grant: got valid=%b grant=%b required 1/01", o_valid, o_grant);
        end
        checks++;
        if ({o_access, o_address, o_write_data, o_strobe} !== {RGGEN_WRITE, 8'h10, 32'hDEAD_BEEF, 4'hF}) begin
            errors++;
            $display("[TB] FAIL write_command: got %h %h %h %h required 3 10 deadbeef f", o_access, o_address, o_write_data, o_strobe);
        end
        respond(0, RGGEN_OKAY, 32'h0);
        set_req(0, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
        checks++;
        if (o_valid !== 1'b0 || o_grant !== 2'b00 || o_req_ready !== 2'b00) begin
            errors++;
            $display("[TB] FAIL write_release: got valid=%b grant=%b ready=%b required 0/00/00", o_valid, o_grant, o_req_ready);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        set_req(0, 1'b1, RGGEN_READ, 8'h04, 32'h0, 4'h0);
        set_req(1, 1'b1, RGGEN_READ, 8'h08, 32'h0, 4'h0);
        tick();
        checks++;
        if (o_grant !== 2'b01 || o_address !== 8'h04 || o_access !== RGGEN_READ) begin
            errors++;
            $display("[TB] FAIL simul_first: got grant=%b addr=%h acc=%b required 01/04/10", o_grant, o_address, o_access);
        end
        respond(0, RGGEN_OKAY, 32'h1111_1111);
        set_req(0, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_bubble: o_valid=%b required 0", o_valid);
        end
        tick();
        checks++;
        if (o_grant !== 2'b10 || o_address !== 8'h08) begin
            errors++;
            $display("[TB] FAIL simul_second: got grant=%b addr=%h required 10/08", o_grant, o_address);
        end
        respond(1, RGGEN_OKAY, 32'h2222_2222);
        set_req(1, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic test_fairness();
        logic [1:0] exp_grant;
        set_req(0, 1'b1, RGGEN_READ, 8'h0C, 32'h0, 4'h0);
        set_req(1, 1'b1, RGGEN_READ, 8'h1C, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            wait_busy(4, "fair");
            exp_grant = '0;
            exp_grant[exp_ptr] = 1'b1;
            checks++;
            if (o_grant !== exp_grant) begin
                errors++;
                $display("[TB] FAIL fair_grant%0d: got %b required %b", k, o_grant, exp_grant);
            end
            respond(exp_ptr, RGGEN_OKAY, 32'hA000_0000 + 32'(k));
        end
        set_req(0, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
        set_req(1, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic test_hold_command();
        set_req(1, 1'b1, RGGEN_READ, 8'h20, 32'h0, 4'h0);
        wait_busy(3, "hold");
        checks++;
        if (o_grant !== 2'b10 || o_address !== 8'h20) begin
            errors++;
            $display("[TB] FAIL hold_grant: got grant=%b addr=%h required 10/20", o_grant, o_address);
        end
        set_req(1, 1'b1, RGGEN_READ, 8'h24, 32'h0, 4'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (o_address !== 8'h20 || o_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_addr%0d: got addr=%h valid=%b required 20/1", k, o_address, o_valid);
            end
        end
        respond(1, RGGEN_OKAY, 32'h3333_3333);
        set_req(1, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic test_reset_mid_access();
        set_req(0, 1'b1, RGGEN_WRITE, 8'h30, 32'h0000_0030, 4'h3);
        wait_busy(3, "midrst_pre");
        respond(0, RGGEN_OKAY, 32'h0);
        set_req(0, 1'b1, RGGEN_WRITE, 8'h40, 32'h0000_0040, 4'hF);
        set_req(1, 1'b1, RGGEN_READ, 8'h44, 32'h0, 4'h0);
        wait_busy(3, "midrst_busy");
        checks++;
        if (o_grant !== 2'b10) begin
            errors++;
            $display("[TB] FAIL midrst_ptr: got grant=%b required 10", o_grant);
        end
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_grant !== 2'b00 || o_req_ready !== 2'b00 || o_address !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrst_abort: got valid=%b grant=%b ready=%b addr=%h required 0/00/00/00", o_valid, o_grant, o_req_ready, o_address);
        end
        i_ready = 1'b0;
        tick();
        i_rst_n = 1'b1;
        exp_ptr = 0;
        tick();
        checks++;
        if (o_grant !== 2'b01 || o_address !== 8'h40) begin
            errors++;
            $display("[TB] FAIL midrst_fresh: got grant=%b addr=%h required 01/40", o_grant, o_address);
        end
        respond(0, RGGEN_OKAY, 32'h0);
        set_req(0, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
        wait_busy(3, "midrst_next");
        checks++;
        if (o_grant !== 2'b10 || o_address !== 8'h44) begin
            errors++;
            $display("[TB] FAIL midrst_next: got grant=%b addr=%h required 10/44", o_grant, o_address);
        end
        respond(1, RGGEN_OKAY, 32'h4444_4444);
        set_req(1, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
    endtask

    task automatic test_idle_ready_and_error();
        i_ready = 1'b1;
        i_status = RGGEN_SLAVE_ERROR;
        i_read_data = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (o_req_ready !== 2'b00 || o_req_status !== 4'h0 || o_req_read_data !== 64'h0) begin
            errors++;
            $display("[TB] FAIL idle_ready: got ready=%b status=%h data=%h required zeros", o_req_ready, o_req_status, o_req_read_data);
        end
        tick();
        i_ready = 1'b0;
        i_status = '0;
        i_read_data = '0;
        checks++;
        if (o_valid !== 1'b0 || o_grant !== 2'b00) begin
            errors++;
            $display("[TB] FAIL idle_state: got valid=%b grant=%b required 0/00", o_valid, o_grant);
        end
        set_req(0, 1'b1, RGGEN_WRITE, 8'h50, 32'h0000_0050, 4'h1);
        wait_busy(3, "err");
        checks++;
        if (o_grant !== 2'b01 || o_strobe !== 4'h1) begin
            errors++;
            $display("[TB] FAIL err_grant: got grant=%b strobe=%h required 01/1", o_grant, o_strobe);
        end
        respond(0, RGGEN_SLAVE_ERROR, 32'hCAFE_F00D);
        set_req(0, 1'b0, 2'b00, 8'h00, 32'h0, 4'h0);
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_req_valid = '0;
        i_req_access = '0;
        i_req_address = '0;
        i_req_write_data = '0;
        i_req_strobe = '0;
        i_ready = 1'b0;
        i_status = '0;
        i_read_data = '0;
        tick();
        test_reset();
        test_single_write();
        test_simultaneous();
        test_fairness();
        test_hold_command();
        test_reset_mid_access();
        test_idle_ready_and_error();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
